// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between control unit and pc_sequencer.
// master = control/datapath side, slave = sequencer.
interface pc_sequencer_if;
    localparam int unsigned XLEN = 32;

    logic            stall;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            exc_req;
    logic            halt;
    logic            resume;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            fetch_valid;
    logic            misalign_err;
    logic [1:0]      seq_state;

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target,
               exc_req, halt, resume,
        input  pc, pc_plus4, fetch_valid, misalign_err, seq_state
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target,
               exc_req, halt, resume,
        output pc, pc_plus4, fetch_valid, misalign_err, seq_state
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT control, next-PC selection, misaligned-target trap.
// Optional MIPS branch delay slot enabled by defining PC_DELAY_SLOT_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic            misalign_q;
    logic [XLEN-1:0] pc_plus4;
    logic            redir_valid;
    logic [XLEN-1:0] redir_target;
    logic            redir_misalign;

`ifdef PC_DELAY_SLOT_EN
    logic            pend_valid_q;
    logic [XLEN-1:0] pend_target_q;
    logic            pend_misalign;

    assign pend_misalign = |pend_target_q[1:0];
`endif

    assign pc_plus4 = pc_q + XLEN'(4);

    // Redirect source select: jump outranks a taken branch.
    always_comb begin
        redir_valid  = 1'b0;
        redir_target = '0;
        if (bus.jump) begin
            redir_valid  = 1'b1;
            redir_target = bus.jump_target;
        end else if (bus.branch_taken) begin
            redir_valid  = 1'b1;
            redir_target = bus.branch_target;
        end
    end

    assign redir_misalign = |redir_target[1:0];

    // Sequencer FSM and PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
`ifdef PC_DELAY_SLOT_EN
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
`endif
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;

                ST_RUN: begin
                    if (bus.exc_req) begin
                        pc_q <= EXC_VECTOR;
`ifdef PC_DELAY_SLOT_EN
                        pend_valid_q <= 1'b0;
`endif
                    end else if (!bus.stall) begin
                        if (bus.halt) begin
                            state_q <= ST_HALT;
`ifdef PC_DELAY_SLOT_EN
                        end else if (pend_valid_q) begin
                            // Delay slot retiring: load the held target, ignore new redirects.
                            pc_q         <= pend_misalign ? EXC_VECTOR : pend_target_q;
                            misalign_q   <= pend_misalign;
                            pend_valid_q <= 1'b0;
                        end else if (redir_valid) begin
                            pend_valid_q  <= 1'b1;
                            pend_target_q <= redir_target;
                            pc_q          <= pc_plus4;
`else
                        end else if (redir_valid) begin
                            pc_q       <= redir_misalign ? EXC_VECTOR : redir_target;
                            misalign_q <= redir_misalign;
`endif
                        end else begin
                            pc_q <= pc_plus4;
                        end
                    end
                end

                ST_HALT: begin
                    if (bus.exc_req) begin
                        pc_q    <= EXC_VECTOR;
                        state_q <= ST_RUN;
`ifdef PC_DELAY_SLOT_EN
                        pend_valid_q <= 1'b0;
`endif
                    end else if (!bus.stall && bus.resume) begin
                        pc_q    <= pc_plus4;
                        state_q <= ST_RUN;
                    end
                end

                default: state_q <= ST_BOOT;
            endcase
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_plus4;
    // Qualifies the current fetch, so it follows this cycle's stall.
    assign bus.fetch_valid  = (state_q == ST_RUN) && !bus.stall;
    assign bus.misalign_err = misalign_q;
    assign bus.seq_state    = 2'(state_q);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed literal checks plus randomized run vs behavioural model.
module tb_pc_sequencer;
    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] EXC = 32'h0000_0080;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    bit   chk_en;

    // Behavioural model: mode 0 = boot, 1 = run, 2 = halt.
    logic [31:0] m_pc;
    int          m_mode;
    bit          m_mis;
    bit          m_pend;
    logic [31:0] m_pend_t;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EXC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Literal expectation applied to both DUT and model.
    task automatic chk_lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                           input logic [31:0] exp);
        chk(name, act, exp);
        chk({name, "_model"}, mdl, exp);
    endtask

    task automatic compare_all();
        if (chk_en) begin
            chk("pc", bus.pc, m_pc);
            chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
            chk("fetch_valid", 32'(bus.fetch_valid), 32'((m_mode == 1) && !bus.stall));
            chk("misalign_err", 32'(bus.misalign_err), 32'(m_mis));
            chk("seq_state", 32'(bus.seq_state), 32'(m_mode));
        end
    endtask

    function automatic bit aligned(input logic [31:0] a);
        return (a % 4) == 0;
    endfunction

    // One clock of the reference behaviour, from the inputs seen at this edge.
    task automatic model_step();
        logic [31:0] tgt;
        bit          want;
        if (rst) begin
            m_pc = RV; m_mode = 0; m_mis = 0; m_pend = 0;
            return;
        end
        m_mis = 0;
        want  = bus.jump || bus.branch_taken;
        tgt   = bus.jump ? bus.jump_target : bus.branch_target;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (bus.exc_req) begin
                m_pc = EXC; m_pend = 0;
            end else if (bus.stall) begin
                // hold
            end else if (bus.halt) begin
                m_mode = 2;
`ifdef PC_DELAY_SLOT_EN
            end else if (m_pend) begin
                m_pend = 0;
                if (aligned(m_pend_t)) m_pc = m_pend_t;
                else begin m_pc = EXC; m_mis = 1; end
            end else if (want) begin
                m_pend = 1; m_pend_t = tgt; m_pc = m_pc + 32'd4;
`else
            end else if (want) begin
                if (aligned(tgt)) m_pc = tgt;
                else begin m_pc = EXC; m_mis = 1; end
`endif
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (bus.exc_req) begin
                m_pc = EXC; m_mode = 1; m_pend = 0;
            end else if (!bus.stall && bus.resume) begin
                m_pc = m_pc + 32'd4; m_mode = 1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_in();
        bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0;
        bus.jump = 0; bus.jump_target = '0; bus.exc_req = 0;
        bus.halt = 0; bus.resume = 0;
    endtask

    task automatic goto(input logic [31:0] a);
        bus.jump = 1; bus.jump_target = a;
        tick();
        bus.jump = 0;
`ifdef PC_DELAY_SLOT_EN
        tick();
`endif
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 9) != 0) t = t & 32'hFFFF_FFFC;
        if ($urandom_range(0, 19) == 0) t = 32'hFFFF_FFFC;
        return t;
    endfunction

    initial begin
        total = 0; bad = 0; chk_en = 0;
        m_pc = '0; m_mode = 0; m_mis = 0; m_pend = 0; m_pend_t = '0;
        clear_in();
        rst = 1;
        tick();
        chk_en = 1;
        tick();
        chk_lit("rst_pc", bus.pc, m_pc, 32'h0);
        chk_lit("rst_state", 32'(bus.seq_state), 32'(m_mode), 32'd0);
        chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        rst = 0;
        chk("boot_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        tick();
        chk_lit("run_pc0", bus.pc, m_pc, 32'h0);
        chk_lit("run_state", 32'(bus.seq_state), 32'(m_mode), 32'd1);
        chk("run_fetch_valid", 32'(bus.fetch_valid), 32'd1);
        tick();
        chk_lit("run_pc4", bus.pc, m_pc, 32'h4);
        tick();
        chk_lit("run_pc8", bus.pc, m_pc, 32'h8);

`ifndef PC_DELAY_SLOT_EN
        tick(); tick();
        chk_lit("pc_10", bus.pc, m_pc, 32'h10);
        bus.jump = 1; bus.jump_target = 32'h200;
        bus.branch_taken = 1; bus.branch_target = 32'h300;
        tick();
        chk_lit("jump_wins", bus.pc, m_pc, 32'h200);
        bus.jump = 0; bus.branch_target = 32'h40;
        tick();
        chk_lit("branch_only", bus.pc, m_pc, 32'h40);
        clear_in();
        goto(32'h20);
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_lit("stall_hold", bus.pc, m_pc, 32'h20);
            chk("stall_fv", 32'(bus.fetch_valid), 32'd0);
        end
        bus.exc_req = 1;
        tick();
        chk_lit("exc_in_stall", bus.pc, m_pc, 32'h80);
        clear_in();
        bus.jump = 1; bus.jump_target = 32'h102;
        tick();
        chk_lit("misalign_pc", bus.pc, m_pc, 32'h80);
        chk_lit("misalign_err", 32'(bus.misalign_err), 32'(m_mis), 32'd1);
        clear_in();
        tick();
        chk_lit("misalign_pulse", 32'(bus.misalign_err), 32'(m_mis), 32'd0);
        chk_lit("after_trap_pc", bus.pc, m_pc, 32'h84);
        goto(32'h30);
        bus.halt = 1;
        tick();
        chk_lit("halt_state", 32'(bus.seq_state), 32'(m_mode), 32'd2);
        bus.halt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_lit("halt_hold", bus.pc, m_pc, 32'h30);
            chk("halt_fv", 32'(bus.fetch_valid), 32'd0);
        end
        bus.resume = 1;
        tick();
        chk_lit("resume_pc", bus.pc, m_pc, 32'h34);
        bus.resume = 0;
        goto(32'hFFFF_FFFC);
        chk("wrap_plus4", bus.pc_plus4, 32'h0);
        tick();
        chk_lit("wrap_pc", bus.pc, m_pc, 32'h0);
        chk("wrap_no_err", 32'(bus.misalign_err), 32'd0);
`else
        goto(32'h40);
        bus.branch_taken = 1; bus.branch_target = 32'h100;
        tick();
        chk_lit("ds_slot", bus.pc, m_pc, 32'h44);
        bus.branch_taken = 0;
        tick();
        chk_lit("ds_target", bus.pc, m_pc, 32'h100);
        goto(32'h40);
        bus.branch_taken = 1; bus.branch_target = 32'h100;
        tick();
        bus.branch_taken = 0; bus.stall = 1;
        tick(); tick();
        chk_lit("ds_stall_hold", bus.pc, m_pc, 32'h44);
        bus.stall = 0;
        tick();
        chk_lit("ds_after_stall", bus.pc, m_pc, 32'h100);
`endif

        // Randomized phase against the model.
        for (int n = 0; n < 3000; n++) begin
            rst              = ($urandom_range(0, 99) == 0);
            bus.stall        = ($urandom_range(0, 99) < 15);
            bus.branch_taken = ($urandom_range(0, 99) < 15);
            bus.branch_target = rand_target();
            bus.jump         = ($urandom_range(0, 99) < 10);
            bus.jump_target  = rand_target();
            bus.exc_req      = ($urandom_range(0, 99) < 3);
            bus.halt         = ($urandom_range(0, 99) < 4);
            bus.resume       = ($urandom_range(0, 99) < 20);
            tick();
        end
        rst = 0;
        clear_in();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
